// File: rtl/dtcm_arbt_pkg.sv
// Shared widths and requester identifiers for the DTCM arbiter.
package dtcm_arbt_pkg;

    localparam int DTCM_ADDR_WIDTH = 16;
    localparam int XLEN            = 32;

    typedef enum logic {
        REQ_LSU = 1'b0,
        REQ_EXT = 1'b1
    } req_id_t;

endpackage

// File: rtl/dtcm_arbt.sv
// Two-way round-robin arbiter sharing the single-port DTCM between LSU and EXT; zero-cycle command mux,
// one outstanding transaction, grant held on a stalled command, response routed to its owner.
module dtcm_arbt
    import dtcm_arbt_pkg::*;
#(
    parameter int AW = DTCM_ADDR_WIDTH,
    parameter int DW = XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst_n,

    input  logic            i_lsu_cmd_valid,
    output logic            o_lsu_cmd_ready,
    input  logic            i_lsu_cmd_read,
    input  logic [AW-1:0]   i_lsu_cmd_addr,
    input  logic [DW-1:0]   i_lsu_cmd_wdata,
    input  logic [DW/8-1:0] i_lsu_cmd_wmask,
    output logic            o_lsu_rsp_valid,
    input  logic            i_lsu_rsp_ready,
    output logic [DW-1:0]   o_lsu_rsp_rdata,

    input  logic            i_ext_cmd_valid,
    output logic            o_ext_cmd_ready,
    input  logic            i_ext_cmd_read,
    input  logic [AW-1:0]   i_ext_cmd_addr,
    input  logic [DW-1:0]   i_ext_cmd_wdata,
    input  logic [DW/8-1:0] i_ext_cmd_wmask,
    output logic            o_ext_rsp_valid,
    input  logic            i_ext_rsp_ready,
    output logic [DW-1:0]   o_ext_rsp_rdata,

    output logic            o_dtcm_cmd_valid,
    input  logic            i_dtcm_cmd_ready,
    output logic            o_dtcm_cmd_read,
    output logic [AW-1:0]   o_dtcm_cmd_addr,
    output logic [DW-1:0]   o_dtcm_cmd_wdata,
    output logic [DW/8-1:0] o_dtcm_cmd_wmask,
    input  logic            i_dtcm_rsp_valid,
    output logic            o_dtcm_rsp_ready,
    input  logic [DW-1:0]   i_dtcm_rsp_rdata
);

    logic    r_osd;
    req_id_t r_own;
    req_id_t r_last;
    logic    r_lock_vld;
    req_id_t r_lock_id;

    logic    w_gnt_vld;
    req_id_t w_gnt_id;
    logic    w_can_issue;
    logic    w_cmd_hsk;
    logic    w_rsp_hsk;
    logic    w_own_rsp_ready;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = REQ_LSU;
        if (r_lock_vld) begin
            w_gnt_id  = r_lock_id;
            w_gnt_vld = (r_lock_id == REQ_EXT) ? i_ext_cmd_valid : i_lsu_cmd_valid;
        end else if (i_lsu_cmd_valid && i_ext_cmd_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = req_id_t'(~r_last);
        end else if (i_lsu_cmd_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = REQ_LSU;
        end else if (i_ext_cmd_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = REQ_EXT;
        end
    end

    always_comb begin
        o_dtcm_cmd_read  = 1'b0;
        o_dtcm_cmd_addr  = '0;
        o_dtcm_cmd_wdata = '0;
        o_dtcm_cmd_wmask = '0;
        if (w_gnt_vld) begin
            if (w_gnt_id == REQ_EXT) begin
                o_dtcm_cmd_read  = i_ext_cmd_read;
                o_dtcm_cmd_addr  = i_ext_cmd_addr;
                o_dtcm_cmd_wdata = i_ext_cmd_wdata;
                o_dtcm_cmd_wmask = i_ext_cmd_wmask;
            end else begin
                o_dtcm_cmd_read  = i_lsu_cmd_read;
                o_dtcm_cmd_addr  = i_lsu_cmd_addr;
                o_dtcm_cmd_wdata = i_lsu_cmd_wdata;
                o_dtcm_cmd_wmask = i_lsu_cmd_wmask;
            end
        end
    end

    // With nothing outstanding any response is stray: accept and drop it.
    assign w_own_rsp_ready  = (r_own == REQ_EXT) ? i_ext_rsp_ready : i_lsu_rsp_ready;
    assign o_dtcm_rsp_ready = r_osd ? w_own_rsp_ready : i_dtcm_rsp_valid;
    assign w_rsp_hsk        = i_dtcm_rsp_valid & o_dtcm_rsp_ready;
    assign w_can_issue      = ~r_osd | w_rsp_hsk;

    assign o_dtcm_cmd_valid = w_gnt_vld & w_can_issue;
    assign w_cmd_hsk        = o_dtcm_cmd_valid & i_dtcm_cmd_ready;
    assign o_lsu_cmd_ready  = w_gnt_vld & (w_gnt_id == REQ_LSU) & w_can_issue & i_dtcm_cmd_ready;
    assign o_ext_cmd_ready  = w_gnt_vld & (w_gnt_id == REQ_EXT) & w_can_issue & i_dtcm_cmd_ready;

    assign o_lsu_rsp_valid  = i_dtcm_rsp_valid & r_osd & (r_own == REQ_LSU);
    assign o_ext_rsp_valid  = i_dtcm_rsp_valid & r_osd & (r_own == REQ_EXT);
    assign o_lsu_rsp_rdata  = i_dtcm_rsp_rdata;
    assign o_ext_rsp_rdata  = i_dtcm_rsp_rdata;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_osd      <= 1'b0;
            r_own      <= REQ_LSU;
            r_last     <= REQ_EXT;
            r_lock_vld <= 1'b0;
            r_lock_id  <= REQ_LSU;
        end else if (w_cmd_hsk) begin
            // A new issue wins over the completing response's clear of osd.
            r_osd      <= 1'b1;
            r_own      <= w_gnt_id;
            r_last     <= w_gnt_id;
            r_lock_vld <= 1'b0;
        end else begin
            if (w_rsp_hsk) begin
                r_osd <= 1'b0;
            end
            if (w_gnt_vld) begin
                r_lock_vld <= 1'b1;
                r_lock_id  <= w_gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_dtcm_arbt.sv
// Directed bench for dtcm_arbt: each step drives inputs, lets logic settle, then checks outputs.
module tb_dtcm_arbt;

    localparam int AW = 16;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
    logic [AW-1:0]   lsu_cmd_addr;
    logic [DW-1:0]   lsu_cmd_wdata;
    logic [DW/8-1:0] lsu_cmd_wmask;
    logic            lsu_rsp_valid, lsu_rsp_ready;
    logic [DW-1:0]   lsu_rsp_rdata;
    logic            ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
    logic [AW-1:0]   ext_cmd_addr;
    logic [DW-1:0]   ext_cmd_wdata;
    logic [DW/8-1:0] ext_cmd_wmask;
    logic            ext_rsp_valid, ext_rsp_ready;
    logic [DW-1:0]   ext_rsp_rdata;
    logic            dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
    logic [AW-1:0]   dtcm_cmd_addr;
    logic [DW-1:0]   dtcm_cmd_wdata;
    logic [DW/8-1:0] dtcm_cmd_wmask;
    logic            dtcm_rsp_valid, dtcm_rsp_ready;
    logic [DW-1:0]   dtcm_rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dtcm_arbt #(.AW(AW), .DW(DW)) u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_lsu_cmd_valid  (lsu_cmd_valid),
        .o_lsu_cmd_ready  (lsu_cmd_ready),
        .i_lsu_cmd_read   (lsu_cmd_read),
        .i_lsu_cmd_addr   (lsu_cmd_addr),
        .i_lsu_cmd_wdata  (lsu_cmd_wdata),
        .i_lsu_cmd_wmask  (lsu_cmd_wmask),
        .o_lsu_rsp_valid  (lsu_rsp_valid),
        .i_lsu_rsp_ready  (lsu_rsp_ready),
        .o_lsu_rsp_rdata  (lsu_rsp_rdata),
        .i_ext_cmd_valid  (ext_cmd_valid),
        .o_ext_cmd_ready  (ext_cmd_ready),
        .i_ext_cmd_read   (ext_cmd_read),
        .i_ext_cmd_addr   (ext_cmd_addr),
        .i_ext_cmd_wdata  (ext_cmd_wdata),
        .i_ext_cmd_wmask  (ext_cmd_wmask),
        .o_ext_rsp_valid  (ext_rsp_valid),
        .i_ext_rsp_ready  (ext_rsp_ready),
        .o_ext_rsp_rdata  (ext_rsp_rdata),
        .o_dtcm_cmd_valid (dtcm_cmd_valid),
        .i_dtcm_cmd_ready (dtcm_cmd_ready),
        .o_dtcm_cmd_read  (dtcm_cmd_read),
        .o_dtcm_cmd_addr  (dtcm_cmd_addr),
        .o_dtcm_cmd_wdata (dtcm_cmd_wdata),
        .o_dtcm_cmd_wmask (dtcm_cmd_wmask),
        .i_dtcm_rsp_valid (dtcm_rsp_valid),
        .o_dtcm_rsp_ready (dtcm_rsp_ready),
        .i_dtcm_rsp_rdata (dtcm_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        lsu_cmd_valid = 0; lsu_cmd_read = 0; lsu_cmd_addr = '0; lsu_cmd_wdata = '0; lsu_cmd_wmask = '0;
        ext_cmd_valid = 0; ext_cmd_read = 0; ext_cmd_addr = '0; ext_cmd_wdata = '0; ext_cmd_wmask = '0;
        lsu_rsp_ready = 0; ext_rsp_ready = 0;
        dtcm_cmd_ready = 0; dtcm_rsp_valid = 0; dtcm_rsp_rdata = '0;

        // Reset: all outputs quiet
        tick(); settle();
        chk("rst_cmd_valid", dtcm_cmd_valid, 0);
        chk("rst_lsu_ready", lsu_cmd_ready, 0);
        chk("rst_ext_ready", ext_cmd_ready, 0);
        chk("rst_lsu_rsp",   lsu_rsp_valid, 0);
        chk("rst_ext_rsp",   ext_rsp_valid, 0);
        chk("rst_rsp_ready", dtcm_rsp_ready, 0);
        chk("rst_addr",      dtcm_cmd_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // LSU-only read, DTCM answers next cycle
        lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 16'h0010;
        dtcm_cmd_ready = 1; lsu_rsp_ready = 1; ext_rsp_ready = 1;
        settle();
        chk("rd_cmd_valid", dtcm_cmd_valid, 1);
        chk("rd_addr",      dtcm_cmd_addr, 16'h0010);
        chk("rd_read",      dtcm_cmd_read, 1);
        chk("rd_lsu_ready", lsu_cmd_ready, 1);
        chk("rd_ext_ready", ext_cmd_ready, 0);
        tick();
        lsu_cmd_valid = 0;
        dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'hDEADBEEF;
        settle();
        chk("rd_lsu_rsp",    lsu_rsp_valid, 1);
        chk("rd_rdata",      lsu_rsp_rdata, 32'hDEADBEEF);
        chk("rd_ext_rsp",    ext_rsp_valid, 0);
        chk("rd_rsp_ready",  dtcm_rsp_ready, 1);
        chk("rd_idle_valid", dtcm_cmd_valid, 0);
        tick();
        dtcm_rsp_valid = 0;

        // Reset again so LSU wins the first conflict, then both request every cycle
        rst_n = 0;
        tick();
        rst_n = 1;
        lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 16'h0020;
        ext_cmd_valid = 1; ext_cmd_read = 1; ext_cmd_addr = 16'h0040;
        settle();
        chk("rr0_addr",      dtcm_cmd_addr, 16'h0020);
        chk("rr0_lsu_ready", lsu_cmd_ready, 1);
        chk("rr0_ext_ready", ext_cmd_ready, 0);
        tick();
        dtcm_rsp_valid = 1;
        settle();
        chk("rr1_lsu_rsp",   lsu_rsp_valid, 1);
        chk("rr1_addr",      dtcm_cmd_addr, 16'h0040);
        chk("rr1_ext_ready", ext_cmd_ready, 1);
        tick(); settle();
        chk("rr2_ext_rsp",   ext_rsp_valid, 1);
        chk("rr2_addr",      dtcm_cmd_addr, 16'h0020);
        chk("rr2_lsu_ready", lsu_cmd_ready, 1);
        tick(); settle();
        chk("rr3_lsu_rsp",   lsu_rsp_valid, 1);
        chk("rr3_addr",      dtcm_cmd_addr, 16'h0040);
        chk("rr3_ext_ready", ext_cmd_ready, 1);
        tick();
        lsu_cmd_valid = 0; ext_cmd_valid = 0;
        settle();
        chk("rr4_ext_rsp",   ext_rsp_valid, 1);
        chk("rr4_cmd_valid", dtcm_cmd_valid, 0);
        tick();
        dtcm_rsp_valid = 0;

        // EXT write stalled by dtcm_cmd_ready=0 while LSU also requests
        dtcm_cmd_ready = 0;
        ext_cmd_valid = 1; ext_cmd_read = 0; ext_cmd_addr = 16'h0080;
        ext_cmd_wdata = 32'h12345678; ext_cmd_wmask = 4'hF;
        settle();
        chk("st1_cmd_valid", dtcm_cmd_valid, 1);
        chk("st1_read",      dtcm_cmd_read, 0);
        chk("st1_ext_ready", ext_cmd_ready, 0);
        tick();
        lsu_cmd_valid = 1; lsu_cmd_addr = 16'h0020;
        settle();
        chk("st2_addr",      dtcm_cmd_addr, 16'h0080);
        chk("st2_wdata",     dtcm_cmd_wdata, 32'h12345678);
        chk("st2_lsu_ready", lsu_cmd_ready, 0);
        tick(); settle();
        chk("st3_addr",      dtcm_cmd_addr, 16'h0080);
        chk("st3_wmask",     dtcm_cmd_wmask, 4'hF);
        chk("st3_lsu_ready", lsu_cmd_ready, 0);
        tick();
        dtcm_cmd_ready = 1;
        settle();
        chk("st4_ext_ready", ext_cmd_ready, 1);
        chk("st4_lsu_ready", lsu_cmd_ready, 0);
        tick();
        ext_cmd_valid = 0;
        settle();
        chk("st5_no_issue",  dtcm_cmd_valid, 0);
        tick();
        dtcm_rsp_valid = 1;
        settle();
        chk("st6_ext_rsp",   ext_rsp_valid, 1);
        chk("st6_lsu_ready", lsu_cmd_ready, 1);
        chk("st6_addr",      dtcm_cmd_addr, 16'h0020);
        tick();

        // Owner LSU stalls its response for two cycles, next LSU command waits
        lsu_rsp_ready = 0; lsu_cmd_addr = 16'h0024;
        settle();
        chk("bp1_lsu_rsp",   lsu_rsp_valid, 1);
        chk("bp1_rsp_ready", dtcm_rsp_ready, 0);
        chk("bp1_cmd_valid", dtcm_cmd_valid, 0);
        tick(); settle();
        chk("bp2_rsp_ready", dtcm_rsp_ready, 0);
        chk("bp2_lsu_ready", lsu_cmd_ready, 0);
        tick();
        lsu_rsp_ready = 1;
        settle();
        chk("bp3_rsp_ready", dtcm_rsp_ready, 1);
        chk("bp3_lsu_ready", lsu_cmd_ready, 1);
        chk("bp3_addr",      dtcm_cmd_addr, 16'h0024);
        tick();
        lsu_cmd_valid = 0;
        settle();
        chk("bp4_lsu_rsp",   lsu_rsp_valid, 1);
        tick();
        dtcm_rsp_valid = 0;

        // Stray response with nothing outstanding
        tick();
        dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'hCAFEF00D;
        settle();
        chk("sy_rsp_ready", dtcm_rsp_ready, 1);
        chk("sy_lsu_rsp",   lsu_rsp_valid, 0);
        chk("sy_ext_rsp",   ext_rsp_valid, 0);
        tick();
        dtcm_rsp_valid = 0;
        settle();
        chk("sy_after_ready", dtcm_rsp_ready, 0);
        chk("sy_after_valid", dtcm_cmd_valid, 0);
        tick();

        // Reset while an EXT read is outstanding
        ext_cmd_valid = 1; ext_cmd_read = 1; ext_cmd_addr = 16'h0100;
        settle();
        chk("mr_ext_ready", ext_cmd_ready, 1);
        tick();
        ext_cmd_valid = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        dtcm_rsp_valid = 1;
        settle();
        chk("mr_ext_rsp",    ext_rsp_valid, 0);
        chk("mr_lsu_rsp",    lsu_rsp_valid, 0);
        chk("mr_rsp_ready",  dtcm_rsp_ready, 1);
        tick();
        dtcm_rsp_valid = 0;
        lsu_cmd_valid = 1; lsu_cmd_addr = 16'h0030;
        ext_cmd_valid = 1;
        settle();
        chk("mr_lsu_ready",  lsu_cmd_ready, 1);
        chk("mr_addr",       dtcm_cmd_addr, 16'h0030);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
